// File: rtl/mandel_tile_requester.sv
// Host-side initiator for the Mandelbrot tile UART link: sends a 13-byte tile request,
// then turns the returned iteration-count bytes into an (x, y)-tagged pixel stream.
module mandel_tile_requester #(
  parameter int N               = 30,
  parameter int BLOCK_SIZE      = 64,
  parameter int TIMEOUT         = 1000000,
  parameter int CMD_SEND_BUFFER = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [N-1:0] c_real_in,
  input  logic [N-1:0] c_imag_in,
  input  logic [N-1:0] c_step_in,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  input  logic         tx_active,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready,
  output logic         pix_valid,
  output logic [7:0]   pix_data,
  output logic [7:0]   pix_x,
  output logic [7:0]   pix_y
);
  localparam int PW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]    LAST_IDX = 4'd12;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, TX_BYTE, TX_WAIT_HI, TX_WAIT_LO, RX} state_t;

  state_t        r_state, w_state_next;
  logic [N-1:0]  r_c_real, r_c_imag, r_c_step;
  logic [3:0]    r_tx_idx;
  logic [TW-1:0] r_to_cnt;
  logic [PW-1:0] r_pos_x, r_pos_y;
  logic          r_tx_start, r_done, r_timeout_err, r_pix_valid;
  logic [7:0]    r_tx_data, r_pix_data, r_pix_x, r_pix_y;

  logic [31:0]   w_real, w_imag, w_step;
  logic [7:0]    w_tx_byte;
  logic          w_accept, w_send, w_progress, w_abort, w_adv_idx, w_rx_enter, w_pix, w_last;
  logic          w_to_hit, w_pos_last;

  assign w_real     = 32'(r_c_real);
  assign w_imag     = 32'(r_c_imag);
  assign w_step     = 32'(r_c_step);
  assign w_to_hit   = (r_to_cnt == TO_LAST);
  assign w_pos_last = (&r_pos_x) & (&r_pos_y);

  always_comb begin
    case (r_tx_idx)
      4'd0:    w_tx_byte = 8'(CMD_SEND_BUFFER);
      4'd1:    w_tx_byte = w_real[31:24];
      4'd2:    w_tx_byte = w_real[23:16];
      4'd3:    w_tx_byte = w_real[15:8];
      4'd4:    w_tx_byte = w_real[7:0];
      4'd5:    w_tx_byte = w_imag[31:24];
      4'd6:    w_tx_byte = w_imag[23:16];
      4'd7:    w_tx_byte = w_imag[15:8];
      4'd8:    w_tx_byte = w_imag[7:0];
      4'd9:    w_tx_byte = w_step[31:24];
      4'd10:   w_tx_byte = w_step[23:16];
      4'd11:   w_tx_byte = w_step[15:8];
      4'd12:   w_tx_byte = w_step[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Progress events win over a timeout expiring in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_send       = 1'b0;
    w_progress   = 1'b0;
    w_abort      = 1'b0;
    w_adv_idx    = 1'b0;
    w_rx_enter   = 1'b0;
    w_pix        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = TX_BYTE;
        end
      end
      TX_BYTE: begin
        if (!tx_active) begin
          w_send       = 1'b1;
          w_state_next = TX_WAIT_HI;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
        end
      end
      TX_WAIT_HI: begin
        if (tx_active) begin
          w_progress   = 1'b1;
          w_state_next = TX_WAIT_LO;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
        end
      end
      TX_WAIT_LO: begin
        if (!tx_active) begin
          w_progress = 1'b1;
          if (r_tx_idx == LAST_IDX) begin
            w_rx_enter   = 1'b1;
            w_state_next = RX;
          end else begin
            w_adv_idx    = 1'b1;
            w_state_next = TX_BYTE;
          end
        end else if (w_to_hit) begin
          w_abort = 1'b1;
        end
      end
      RX: begin
        if (rx_ready) begin
          w_pix      = 1'b1;
          w_progress = 1'b1;
          if (w_pos_last) begin
            w_last       = 1'b1;
            w_state_next = IDLE;
          end
        end else if (w_to_hit) begin
          w_abort = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_abort) w_state_next = IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_c_real      <= '0;
      r_c_imag      <= '0;
      r_c_step      <= '0;
      r_tx_idx      <= '0;
      r_to_cnt      <= '0;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_tx_start    <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_tx_data     <= '0;
      r_pix_data    <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
    end else begin
      r_tx_start  <= w_send;
      r_pix_valid <= w_pix;
      r_done      <= w_last;
      if (w_accept) begin
        r_c_real      <= c_real_in;
        r_c_imag      <= c_imag_in;
        r_c_step      <= c_step_in;
        r_tx_idx      <= '0;
        r_timeout_err <= 1'b0;
      end else if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
      if (w_send)    r_tx_data <= w_tx_byte;
      if (w_adv_idx) r_tx_idx  <= r_tx_idx + 1'b1;
      if (w_rx_enter) begin
        r_pos_x <= '0;
        r_pos_y <= '0;
        r_pix_x <= '0;
        r_pix_y <= '0;
      end
      // Raster order, x fastest; the power-of-two edge makes x wrap for free.
      if (w_pix) begin
        r_pix_data <= rx_data;
        r_pix_x    <= 8'(r_pos_x);
        r_pix_y    <= 8'(r_pos_y);
        r_pos_x    <= r_pos_x + 1'b1;
        if (&r_pos_x) r_pos_y <= r_pos_y + 1'b1;
      end
      if ((r_state == IDLE) || w_progress || w_abort) r_to_cnt <= '0;
      else                                             r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // done is registered, so busy is stretched through the done cycle itself.
  assign busy        = (r_state != IDLE) | r_done;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
endmodule

// File: tb/tb_mandel_tile_requester.sv
// Bench for mandel_tile_requester: UART tx responder model, pixel monitor, table and random tiles.
module tb_mandel_tile_requester;
  localparam int BS = 64;
  localparam int TO = 1000;

  logic        CLK = 1'b0;
  logic        RST_N, start, tx_active, rx_ready;
  logic [29:0] c_real_in, c_imag_in, c_step_in;
  logic [7:0]  rx_data;
  logic        busy, done, timeout_err, tx_start, pix_valid;
  logic [7:0]  tx_data, pix_data, pix_x, pix_y;

  typedef struct { logic [7:0] x; logic [7:0] y; logic [7:0] d; } pix_t;
  typedef struct {
    logic [29:0]  cr;
    logic [29:0]  ci;
    logic [29:0]  cs;
    logic [103:0] exp;
    int           npix;
    int           hold;
  } vec_t;

  pix_t       pq[$];
  logic [7:0] txq[$];
  logic [7:0] sent[$];
  int done_total = 0;
  int total = 0, bad = 0;
  int tx_mode = 0, tx_hold = 10;
  int tx_base = 0, pix_base = 0, done_base = 0;

  mandel_tile_requester #(.N(30), .BLOCK_SIZE(BS), .TIMEOUT(TO), .CMD_SEND_BUFFER(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start),
    .c_real_in(c_real_in), .c_imag_in(c_imag_in), .c_step_in(c_step_in),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .tx_data(tx_data), .tx_start(tx_start), .tx_active(tx_active),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y)
  );

  always #5 CLK = ~CLK;

  // UART tx responder: records each strobed byte and stays active for tx_hold cycles.
  initial begin : tx_model
    int hold;
    hold = 0;
    tx_active = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST_N !== 1'b1) begin
        tx_active = 1'b0;
        hold = 0;
      end else if (tx_start === 1'b1) begin
        txq.push_back(tx_data);
        if (tx_mode == 0) begin
          tx_active = 1'b1;
          hold = tx_hold;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_active = 1'b0;
      end
    end
  end

  initial begin : pix_monitor
    pix_t p;
    forever begin
      @(negedge CLK);
      if (pix_valid === 1'b1) begin
        p.x = pix_x;
        p.y = pix_y;
        p.d = pix_data;
        pq.push_back(p);
      end
      if (done === 1'b1) done_total++;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [103:0] model_bytes(input logic [29:0] a, input logic [29:0] b,
                                               input logic [29:0] c);
    return {8'h01, 2'b00, a, 2'b00, b, 2'b00, c};
  endfunction

  task automatic send_rx(input logic [7:0] v, input int gap);
    repeat (gap) @(negedge CLK);
    rx_data  = v;
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
  endtask

  task automatic begin_txn(input logic [29:0] cr, input logic [29:0] ci, input logic [29:0] cs);
    tx_base   = txq.size();
    pix_base  = pq.size();
    done_base = done_total;
    c_real_in = cr;
    c_imag_in = ci;
    c_step_in = cs;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clear", timeout_err, 0);
  endtask

  // Wait for all 13 bytes; optionally hammer start/rx_ready/inputs meanwhile.
  task automatic run_tx(input logic [103:0] exp, input bit noise);
    int guard, busy_low;
    logic [103:0] e;
    logic [7:0] got;
    e = exp;
    guard = 0;
    busy_low = 0;
    while (!((txq.size() - tx_base) == 13 && tx_active == 1'b0) && guard < 1000) begin
      @(negedge CLK);
      guard++;
      if (busy !== 1'b1) busy_low++;
      if (noise) begin
        start     = ($urandom_range(0, 5) == 0);
        rx_ready  = ($urandom_range(0, 2) == 0);
        rx_data   = 8'($urandom);
        c_real_in = 30'($urandom);
        c_imag_in = 30'($urandom);
        c_step_in = 30'($urandom);
      end
    end
    start = 1'b0;
    rx_ready = 1'b0;
    @(negedge CLK);
    chk("tx_finished", guard < 1000, 1);
    chk("tx_count", txq.size() - tx_base, 13);
    for (int j = 0; j < 13; j++) begin
      got = (tx_base + j < txq.size()) ? txq[tx_base + j] : 8'hxx;
      chk($sformatf("tx_byte%0d", j), got, e[103 - 8*j -: 8]);
    end
    chk("busy_in_tx", busy_low, 0);
    chk("no_pix_in_tx", pq.size() - pix_base, 0);
  endtask

  task automatic feed_pixels(input int n, input bit ramp, input bit poke);
    logic [7:0] v;
    sent.delete();
    for (int i = 0; i < n; i++) begin
      v = ramp ? 8'(i % 256) : 8'($urandom);
      sent.push_back(v);
      if (poke && i == n / 2) begin
        c_real_in = 30'($urandom);
        c_imag_in = 30'($urandom);
        c_step_in = 30'($urandom);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
      end
      send_rx(v, ramp ? 0 : $urandom_range(0, 2));
    end
  endtask

  task automatic check_pixels(input int n);
    pix_t p;
    chk("pix_count", pq.size() - pix_base, n);
    for (int i = 0; i < n && pix_base + i < pq.size(); i++) begin
      p = pq[pix_base + i];
      chk($sformatf("pixel%0d", i), {p.x, p.y, p.d}, {8'(i % BS), 8'(i / BS), sent[i]});
    end
  endtask

  task automatic measure_timeout(input int exp_k);
    int k;
    k = 0;
    while (k < exp_k + 50 && timeout_err !== 1'b1) begin
      @(negedge CLK);
      k++;
    end
    chk("timeout_cycles", k, exp_k);
    chk("idle_after_timeout", {busy, timeout_err}, 2'b01);
    chk("no_done_on_timeout", done_total - done_base, 0);
  endtask

  task automatic txn_timeout(input logic [29:0] cr, input logic [29:0] ci, input logic [29:0] cs,
                             input logic [103:0] exp, input int npix, input int hold,
                             input string tag);
    tx_hold = hold;
    begin_txn(cr, ci, cs);
    run_tx(exp, 1'b1);
    feed_pixels(npix, 1'b0, 1'b1);
    measure_timeout(TO);
    chk("tx_count_after_rx", txq.size() - tx_base, 13);
    check_pixels(npix);
    $display("txn %s: c_real=%h c_imag=%h c_step=%h hold=%0d pixels=%0d", tag, cr, ci, cs,
             hold, npix);
  endtask

  initial begin : main
    vec_t vt[4];
    logic [29:0] a, b, c;
    vt[0] = '{30'h02ABCDEF, 30'h3FFFFFFF, 30'h00000400,
              104'h01_02ABCDEF_3FFFFFFF_00000400, 100, 10};
    vt[1] = '{30'h00000000, 30'h00000000, 30'h00000000,
              104'h01_00000000_00000000_00000000, 5, 1};
    vt[2] = '{30'h3FFFFFFF, 30'h12345678, 30'h00000001,
              104'h01_3FFFFFFF_12345678_00000001, 70, 3};
    vt[3] = '{30'h20000000, 30'h00A5005A, 30'h3C3C3C3C,
              104'h01_20000000_00A5005A_3C3C3C3C, 64, 1};

    RST_N = 1'b0;
    start = 1'b0;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    c_real_in = '0;
    c_imag_in = '0;
    c_step_in = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {busy, done, timeout_err, tx_start, tx_data, pix_valid, pix_data,
                       pix_x, pix_y}, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    send_rx(8'h55, 0);
    @(negedge CLK);
    chk("idle_rx_ignored", pq.size(), 0);

    for (int i = 0; i < 4; i++)
      txn_timeout(vt[i].cr, vt[i].ci, vt[i].cs, vt[i].exp, vt[i].npix, vt[i].hold, "table");

    // Full tile: ramp data, done on the final pixel only.
    tx_hold = 10;
    begin_txn(vt[0].cr, vt[0].ci, vt[0].cs);
    run_tx(vt[0].exp, 1'b0);
    feed_pixels(BS * BS, 1'b1, 1'b1);
    chk("last_pixel_done", {done, pix_valid, pix_x, pix_y}, {1'b1, 1'b1, 8'd63, 8'd63});
    @(negedge CLK);
    chk("busy_after_done", busy, 0);
    chk("done_count", done_total - done_base, 1);
    chk("no_err_full_tile", timeout_err, 0);
    check_pixels(BS * BS);
    $display("txn full: c_real=%h pixels=%0d", vt[0].cr, BS * BS);

    for (int r = 0; r < 3; r++) begin
      a = 30'($urandom);
      b = 30'($urandom);
      c = 30'($urandom);
      txn_timeout(a, b, c, model_bytes(a, b, c), $urandom_range(1, 130),
                  $urandom_range(1, 12), "random");
    end

    // Asynchronous reset in the middle of the pixel phase.
    tx_hold = 4;
    a = 30'($urandom);
    b = 30'($urandom);
    c = 30'($urandom);
    begin_txn(a, b, c);
    run_tx(model_bytes(a, b, c), 1'b0);
    feed_pixels(2000, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset_outs", {busy, done, timeout_err, tx_start, tx_data, pix_valid, pix_data,
                             pix_x, pix_y}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_pixels(2000);
    chk("reset_no_done", done_total - done_base, 0);
    $display("txn reset: c_real=%h pixels=2000 then reset", a);
    txn_timeout(c, a, b, model_bytes(c, a, b), 0, 6, "after_reset");

    // Responder never goes active: one strobe, then abort.
    tx_mode = 1;
    begin_txn(vt[2].cr, vt[2].ci, vt[2].cs);
    measure_timeout(TO);
    chk("stuck_tx_count", txq.size() - tx_base, 1);
    tx_mode = 0;
    $display("txn stuck_tx: single strobe then timeout");

    txn_timeout(vt[3].cr, vt[3].ci, vt[3].cs, vt[3].exp, 3, 2, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
